branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 115 +++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - queue of outstanding branch predictions checked against execute resolutions
// Raises a one-cycle redirect on mispredict and flushes the wrong-path queue.
module branch_resolve #(
    parameter int depth      = 4,
    parameter int word_width = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    input  logic [word_width-1:0]      pred_target,
    input  logic [word_width-1:0]      pred_fallthrough,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [word_width-1:0]      res_target,
    output logic                       handling_pred,
    output logic                       branch_taken,
    output logic                       mispredict,
    output logic [word_width-1:0]      redirect_addr,
    output logic                       res_error,
    output logic [$clog2(depth):0]     occupancy,
    output logic [15:0]                resolved_cnt,
    output logic [15:0]                mispred_cnt
);

    localparam int aw = $clog2(depth);
    localparam int ow = aw + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state, state_next;
    logic [aw-1:0]         wr_ptr, rd_ptr;
    logic                  q_taken    [depth];
    logic [word_width-1:0] q_target   [depth];
    logic [word_width-1:0] q_fall     [depth];

    logic                  run;
    logic                  do_push, do_pop, is_mis, flush;
    logic                  head_taken;
    logic [word_width-1:0] head_target, head_fall;

    always_comb begin
        run         = (state == RUN);
        pred_ready  = run && (occupancy != ow'(depth));
        do_push     = pred_valid && pred_ready;
        do_pop      = run && res_valid && (occupancy != '0);
        head_taken  = q_taken[rd_ptr];
        head_target = q_target[rd_ptr];
        head_fall   = q_fall[rd_ptr];
        // a correctly predicted not-taken branch never looks at the fallthrough
        is_mis      = (head_taken != res_taken) ||
                      (head_taken && res_taken && (head_target != res_target));
        flush       = do_pop && is_mis;
        state_next  = state;
        case (state)
            RUN:     if (flush) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Entry storage carries no reset; pointers and occupancy alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            q_taken[wr_ptr]  <= pred_taken;
            q_target[wr_ptr] <= pred_target;
            q_fall[wr_ptr]   <= pred_fallthrough;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            resolved_cnt  <= '0;
            mispred_cnt   <= '0;
            handling_pred <= 1'b0;
            branch_taken  <= 1'b0;
            mispredict    <= 1'b0;
            res_error     <= 1'b0;
            redirect_addr <= '0;
        end else begin
            state         <= state_next;
            handling_pred <= do_pop;
            branch_taken  <= do_pop && res_taken;
            mispredict    <= flush;
            res_error     <= run && res_valid && (occupancy == '0);
            if (flush)
                redirect_addr <= res_taken ? res_target : head_fall;

            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + aw'(1);
                if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
                case ({do_push, do_pop})
                    2'b10:   occupancy <= occupancy + ow'(1);
                    2'b01:   occupancy <= occupancy - ow'(1);
                    default: occupancy <= occupancy;
                endcase
            end

            if (do_pop && (resolved_cnt != 16'hFFFF))
                resolved_cnt <= resolved_cnt + 16'd1;
            if (flush && (mispred_cnt != 16'hFFFF))
                mispred_cnt <= mispred_cnt + 16'd1;
        end
    end

endmodule
